// File: rtl/sync_pkg.sv
// Shared channel map and default widths for the input conditioner and the FSM bus wiring.
// Also holds the per-channel registered output bundle used by the glitch filter.
package sync_pkg;

    localparam int CH_RESET     = 0;
    localparam int CH_START     = 1;
    localparam int CH_FG        = 2;
    localparam int CH_PHASE     = 3;
    localparam int CH_WIRE      = 4;
    localparam int CH_DET_READY = 5;
    localparam int N_CH         = 6;

    localparam int FILT_W_DEF   = 8;
    localparam int PER_W_DEF    = 16;

    // Registered per-channel state presented to the rest of the design.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } ch_out_t;

endpackage

// File: rtl/sync_input_conditioner_if.sv
// Bundle of raw inputs, configuration and conditioned outputs of the input conditioner.
// master drives raw inputs/config and consumes results; slave is the conditioner itself.
interface sync_input_conditioner_if #(
    parameter int N_CH   = sync_pkg::N_CH,
    parameter int FILT_W = sync_pkg::FILT_W_DEF,
    parameter int PER_W  = sync_pkg::PER_W_DEF
);
    logic [N_CH-1:0]   raw_in;
    logic [N_CH-1:0]   ch_enable;
    logic [FILT_W-1:0] cfg_filter_len;

    logic [N_CH-1:0]   level_out;
    logic [N_CH-1:0]   rise_pulse;
    logic [N_CH-1:0]   fall_pulse;
    logic [PER_W-1:0]  phase_period;
    logic              phase_period_valid;
    logic              phase_period_ovf;

    modport master (
        output raw_in,
        output ch_enable,
        output cfg_filter_len,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  phase_period,
        input  phase_period_valid,
        input  phase_period_ovf
    );

    modport slave (
        input  raw_in,
        input  ch_enable,
        input  cfg_filter_len,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output phase_period,
        output phase_period_valid,
        output phase_period_ovf
    );

endinterface

// File: rtl/sync_glitch_filter.sv
// One input channel: 2-FF synchroniser, stability-count glitch filter and registered
// rise/fall pulses. thr is the filter length minus one, precomputed by the parent.
module sync_glitch_filter
    import sync_pkg::*;
#(
    parameter int FILT_W = FILT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              raw_in,
    input  logic              enable,
    input  logic [FILT_W-1:0] thr,
    output logic              level_out,
    output logic              rise_pulse,
    output logic              fall_pulse
);

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    ch_out_t           out_q, out_d;

    always_comb begin
        s1_d       = raw_in;
        s2_d       = s1_q;
        cnt_d      = cnt_q;
        out_d      = out_q;
        out_d.rise = 1'b0;
        out_d.fall = 1'b0;

        if (!enable) begin
            cnt_d       = '0;
            out_d.level = 1'b0;
        end else if (s2_q == out_q.level) begin
            cnt_d = '0;
        end else if (cnt_q >= thr) begin
            // >= rather than == so a live shortening of the length accepts immediately.
            out_d.level = s2_q;
            out_d.rise  = s2_q;
            out_d.fall  = ~s2_q;
            cnt_d       = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign level_out  = out_q.level;
    assign rise_pulse = out_q.rise;
    assign fall_pulse = out_q.fall;

endmodule

// File: rtl/sync_input_conditioner.sv
// Conditions the raw field inputs for the scenario FSM: per-channel synchronise/filter/edge
// detect, plus a saturating measurement of the interval between accepted phase rises.
module sync_input_conditioner
    import sync_pkg::*;
#(
    parameter int N_CH   = sync_pkg::N_CH,
    parameter int FILT_W = sync_pkg::FILT_W_DEF,
    parameter int PER_W  = sync_pkg::PER_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    sync_input_conditioner_if.slave    bus
);

    localparam logic [PER_W-1:0] PER_MAX = '1;

    logic [FILT_W-1:0] thr;
    logic [N_CH-1:0]   level_w;
    logic [N_CH-1:0]   rise_w;
    logic [N_CH-1:0]   fall_w;

    // A length of 0 behaves as 1, i.e. threshold 0.
    always_comb begin
        thr = '0;
        if (bus.cfg_filter_len != '0) begin
            thr = bus.cfg_filter_len - 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            sync_glitch_filter #(
                .FILT_W (FILT_W)
            ) u_filter (
                .clk        (clk),
                .rst_n      (rst_n),
                .raw_in     (bus.raw_in[gi]),
                .enable     (bus.ch_enable[gi]),
                .thr        (thr),
                .level_out  (level_w[gi]),
                .rise_pulse (rise_w[gi]),
                .fall_pulse (fall_w[gi])
            );
        end
    endgenerate

    assign bus.level_out  = level_w;
    assign bus.rise_pulse = rise_w;
    assign bus.fall_pulse = fall_w;

    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             armed_q, armed_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        per_cnt_d = per_cnt_q;
        period_d  = period_q;
        armed_d   = armed_q;
        ovf_d     = ovf_q;
        valid_d   = 1'b0;

        if (!bus.ch_enable[CH_PHASE]) begin
            per_cnt_d = '0;
            armed_d   = 1'b0;
        end else begin
            if (per_cnt_q != PER_MAX) begin
                per_cnt_d = per_cnt_q + 1'b1;
            end
            if (rise_w[CH_PHASE]) begin
                // The first rise only starts the measurement; later ones report it.
                if (armed_q) begin
                    period_d = per_cnt_q;
                    valid_d  = 1'b1;
                    ovf_d    = (per_cnt_q == PER_MAX);
                end
                per_cnt_d = PER_W'(1);
                armed_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt_q <= '0;
            period_q  <= '0;
            armed_q   <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            per_cnt_q <= per_cnt_d;
            period_q  <= period_d;
            armed_q   <= armed_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.phase_period       = period_q;
    assign bus.phase_period_valid = valid_q;
    assign bus.phase_period_ovf   = ovf_q;

endmodule
